// File: rtl/cpu_data_responder.sv
`timescale 1ns/1ps
// Purpose: CPU data-memory responder - word RAM plus memory-mapped board I/O bank.
// Latency: reads are combinational (0 cycles); writes commit at the next rising clock edge.
// Backpressure: none - every access completes in the cycle it is presented.
//
// Ports:
//   clock, reset     - single clock domain, asynchronous active-high reset
//   addr, wdata      - byte address (addr[1:0] ignored) and store data from the MEM stage
//   wmem             - store strobe for this cycle
//   rdata            - read data, combinational from addr and current state
//   sw, key          - raw board switches / push-buttons (asynchronous, synchronised here)
//   led, hex         - LED register and 6-digit 7-segment value register
//   timer_irq        - reload timer expired flag
//
// Address map: addr[31]=0 selects RAM (word index addr[ADDR_W+1:2], upper bits alias),
// addr[31]=1 selects the I/O bank (offset addr[4:2]):
//   0 sw (RO)  1 key (RO)  2 led (RW)  3 hex (RW)  4 cycle counter (RO)
//   5 timer reload (RW)  6 expired flag (RW1C)  7 zero (RO)
module cpu_data_responder #(
    parameter int ADDR_W = 6,
    parameter int SW_W   = 10,
    parameter int LED_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              wmem,
    output logic [31:0]       rdata,
    input  logic [SW_W-1:0]   sw,
    input  logic [3:0]        key,
    output logic [LED_W-1:0]  led,
    output logic [23:0]       hex,
    output logic              timer_irq
);

    localparam int RAM_DEPTH = 2 ** ADDR_W;

    // I/O register offsets within the bank
    localparam logic [2:0] OFF_SW     = 3'd0;
    localparam logic [2:0] OFF_KEY    = 3'd1;
    localparam logic [2:0] OFF_LED    = 3'd2;
    localparam logic [2:0] OFF_HEX    = 3'd3;
    localparam logic [2:0] OFF_CYCLE  = 3'd4;
    localparam logic [2:0] OFF_RELOAD = 3'd5;
    localparam logic [2:0] OFF_EXPIRE = 3'd6;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              io_sel;
    logic [ADDR_W-1:0] ram_idx;
    logic [2:0]        io_off;
    logic              ram_we;
    logic              io_we;

    assign io_sel  = addr[31];
    assign ram_idx = addr[ADDR_W+1:2];
    assign io_off  = addr[4:2];
    assign ram_we  = wmem & ~io_sel;
    assign io_we   = wmem &  io_sel;

    // Address bits that only alias; collected so they are visibly intentional.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[30:ADDR_W+2], addr[1:0]};

    // ------------------------------------------------------------------
    // Data RAM: asynchronous read, synchronous write, never reset.
    // A same-cycle read of the word being written sees the old contents
    // because the array only updates at the edge.
    // ------------------------------------------------------------------
    logic [31:0] ram [0:RAM_DEPTH-1];

    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers (two flops each)
    // ------------------------------------------------------------------
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic [3:0]      key_meta;
    logic [3:0]      key_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Output registers, cycle counter and reload timer
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_r;
    logic [23:0]      hex_r;
    logic [31:0]      cycle_cnt;
    logic [31:0]      reload;
    logic [31:0]      tcnt;
    logic             expired;

    logic wr_reload;
    logic wr_clear;
    logic tcnt_last;
    logic tick;

    assign wr_reload = io_we && (io_off == OFF_RELOAD);
    assign wr_clear  = io_we && (io_off == OFF_EXPIRE) && wdata[0];
    assign tcnt_last = (tcnt <= 32'd1);
    // A reload write restarts the period, so it suppresses any expiry due on that edge.
    assign tick      = !wr_reload && (reload != 32'd0) && tcnt_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_r     <= '0;
            hex_r     <= '0;
            cycle_cnt <= '0;
            reload    <= '0;
            tcnt      <= '0;
            expired   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;

            if (io_we && (io_off == OFF_LED)) begin
                led_r <= wdata[LED_W-1:0];
            end
            if (io_we && (io_off == OFF_HEX)) begin
                hex_r <= wdata[23:0];
            end

            // Down-counter: the period is exactly `reload` cycles because the
            // counter reloads on the cycle it would otherwise reach zero.
            if (wr_reload) begin
                reload <= wdata;
                tcnt   <= wdata;
            end else if (reload == 32'd0) begin
                tcnt <= '0;
            end else if (tcnt_last) begin
                tcnt <= reload;
            end else begin
                tcnt <= tcnt - 32'd1;
            end

            // Set has priority over a coincident write-one-to-clear.
            if (tick) begin
                expired <= 1'b1;
            end else if (wr_clear) begin
                expired <= 1'b0;
            end
        end
    end

    assign led       = led_r;
    assign hex       = hex_r;
    assign timer_irq = expired;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] io_rdata;

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_SW:     io_rdata[SW_W-1:0]  = sw_sync;
            OFF_KEY:    io_rdata[3:0]       = key_sync;
            OFF_LED:    io_rdata[LED_W-1:0] = led_r;
            OFF_HEX:    io_rdata[23:0]      = hex_r;
            OFF_CYCLE:  io_rdata            = cycle_cnt;
            OFF_RELOAD: io_rdata            = reload;
            OFF_EXPIRE: io_rdata[0]         = expired;
            default:    io_rdata            = '0;
        endcase
    end

    assign rdata = io_sel ? io_rdata : ram[ram_idx];

endmodule

// File: doc/cpu_data_responder.md
Name: cpu_data_responder

Overview:
- Responder end of the CPU data-memory interface.
- It accepts the MEM-stage address, store data and write strobe, and returns read data within the same cycle.
- It contains word-addressed data RAM plus a small memory-mapped I/O register bank: switches, keys, LEDs, 7-segment value, cycle counter and reload timer.
- It sits between the pipelined CPU and board I/O, replacing a plain data RAM.

Parameters:
ADDR_W, 6, RAM word-index width (RAM depth = 2^ADDR_W words of 32 bits)
SW_W, 10, switch input width
LED_W, 10, LED output width

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
addr  input  32  byte address from CPU ALU result (word-aligned, addr[1:0] ignored)
wdata  input  32  store data from CPU
wmem  input  1  write strobe, 1 = store this cycle
rdata  output  32  read data to CPU, combinational from addr
sw  input  SW_W  raw board switches, asynchronous to clock
key  input  4  raw board push-buttons, asynchronous
led  output  LED_W  LED register
hex  output  24  6-digit 7-segment value register (4 bits per digit)
timer_irq  output  1  copy of timer expired flag

Behaviour:
- Clock and reset: one clock domain. Asynchronous, active-high reset is already decided. Clock port is named clock, reset port is named reset.
- Decode:
  - io_sel = addr[31].
  - io_sel=0: RAM, index = addr[ADDR_W+1:2]; higher address bits are ignored (aliasing).
  - io_sel=1: I/O, offset = addr[4:2]; addr[30:5] are ignored.
- RAM:
  - Asynchronous read: rdata reflects current contents in the same cycle.
  - Write at rising edge when wmem=1 and io_sel=0.
  - Read and write to the same word in one cycle: rdata shows the OLD value; the new value is visible from the next cycle.
  - Contents are not cleared by reset.
- I/O map (offset: access, content):
  - 0: RO, {0, sw_sync}.
  - 1: RO, {28'b0, key_sync}.
  - 2: RW, {0, led}; write takes wdata[LED_W-1:0].
  - 3: RW, {8'b0, hex}; write takes wdata[23:0].
  - 4: RO, cycle counter, 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF -> 0.
  - 5: RW, timer reload value (32-bit).
  - 6: RW1C, {31'b0, expired}; writing wdata[0]=1 clears, wdata[0]=0 leaves unchanged.
  - 7: RO, reads 0.
  - Writes to RO offsets are ignored. Unused read bits are 0.
- Synchronisers:
  - sw and key each pass through a 2-flop synchroniser.
  - A change on the pins appears in rdata after the 2nd rising edge.
- Timer:
  - Internal down-counter tcnt.
  - reload==0: timer stopped, tcnt held at 0, no expiry.
  - reload!=0: each cycle, if tcnt<=1 then tcnt<=reload and expired<=1; else tcnt<=tcnt-1. Period is exactly reload cycles.
  - A write to offset 5 sets reload<=wdata and tcnt<=wdata in the same edge; no expiry is generated on that edge.
  - Expiry and RW1C clear on the same edge: set wins, expired stays 1.
  - timer_irq = expired, registered, no extra delay.
- Reset values: led=0, hex=0, reload=0, tcnt=0, expired=0, timer_irq=0, cycle counter=0, synchronisers=0. rdata is a function of addr and state only.
- Reset asserted mid-operation: all I/O state clears immediately (asynchronously). A RAM write coincident with reset assertion is not guaranteed.
- Latency: read 0 cycles (combinational); write committed at the next rising edge.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to addr 0x00000010, then read 0x10 next cycle -> 0xDEADBEEF. Read 0x14 -> unaffected.
2. Read-during-write: word at 0x20 holds 0x11; same cycle read with write 0x22 -> rdata=0x11, next cycle 0x22. Aliasing: read 0x00000020+(1<<(ADDR_W+2)) -> 0x22.
3. I/O outputs: write 0x3FF to 0x80000008 -> led=0x3FF. Write 0xFF123456 to 0x8000000C -> hex=0x123456, readback 0x00123456. Write to 0x80000000 -> no effect. Reset -> led=0, hex=0.
4. Synchroniser: sw changes 0 -> 0x155 between edges -> rdata at 0x80000000 is 0 after the 1st edge and 0x155 after the 2nd edge.
5. Timer: write reload=3 to 0x80000014 -> timer_irq rises 3 edges later and then every 3 cycles. Write 1 to 0x80000018 on an expiry edge -> stays 1. Write 1 on a non-expiry edge -> 0. Write reload=0 -> no further expiries.
6. Cycle counter: read 0x80000010 on two cycles 5 edges apart -> difference 5. Assert reset mid-run -> counter reads 0 immediately, and all I/O registers return to their reset values.
